// File: rtl/matrix_loader.sv
// matrix_loader: sweeps the coefficient ROM from BASE_ADDR, captures an N x N row-major
// matrix and offers it downstream via mat_valid/mat_ack. Define MATRIX_LOADER_DIAG_CHECK_EN for diag_zero.
module matrix_loader #(
    parameter int DATA_W    = 32,
    parameter int N         = 5,
    parameter int BASE_ADDR = 0,
    parameter int ROM_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    rom_en,
    output logic [4:0]              rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic                    busy,
    output logic                    mat_valid,
    input  logic                    mat_ack,
    output logic [N*N*DATA_W-1:0]   matrix_flat
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
    ,
    output logic                    diag_zero
`endif
);

    localparam int NE = N * N;
    localparam int CW = $clog2(NE + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       rd_cnt;
    logic [CW-1:0]       wr_cnt;
    logic [ROM_LAT-1:0]  cap_sr;
    logic                cap_en;
    logic                last_cap;
    logic [NE*DATA_W-1:0] matrix_nxt;

    // cap_en marks the cycle in which rom_data belongs to an address we issued
    assign cap_en   = cap_sr[ROM_LAT-1];
    assign last_cap = cap_en && (wr_cnt == CW'(NE - 1));

    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        rom_addr  = '0;
        busy      = 1'b0;
        mat_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                rom_en   = 1'b1;
                rom_addr = 5'(BASE_ADDR) + 5'(rd_cnt);
                busy     = 1'b1;
                if (rd_cnt == CW'(NE - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_cap) state_nxt = HOLD;
            end
            HOLD: begin
                mat_valid = 1'b1;
                if (mat_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        matrix_nxt = matrix_flat;
        if (cap_en) begin
            for (int i = 0; i < NE; i++) begin
                if (wr_cnt == CW'(i)) matrix_nxt[i*DATA_W +: DATA_W] = rom_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            cap_sr      <= '0;
            matrix_flat <= '0;
        end else begin
            state       <= state_nxt;
            matrix_flat <= matrix_nxt;
            cap_sr[0]   <= rom_en;
            for (int i = 1; i < ROM_LAT; i++) cap_sr[i] <= cap_sr[i-1];
            if (state == IDLE && start) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (state == FETCH) rd_cnt <= rd_cnt + CW'(1);
                if (cap_en && wr_cnt < CW'(NE)) wr_cnt <= wr_cnt + CW'(1);
            end
        end
    end

`ifdef MATRIX_LOADER_DIAG_CHECK_EN
    logic diag_nxt;

    // Evaluated on the incoming matrix so the last pivot, captured on the HOLD entry edge, is included
    always_comb begin
        diag_nxt = 1'b0;
        for (int r = 0; r < N; r++) begin
            if (matrix_nxt[(r*N + r)*DATA_W +: DATA_W] == '0) diag_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            diag_zero <= 1'b0;
        end else if (state == DRAIN && state_nxt == HOLD) begin
            diag_zero <= diag_nxt;
        end else if (state == HOLD && state_nxt == IDLE) begin
            diag_zero <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: three loader instances (base/latency variants) against ROM models
// and a reference that maps element k to ROM[(BASE+k) mod 32].
module tb_matrix_loader;

    localparam int DATA_W = 32;
    localparam int N      = 5;
    localparam int NE     = N * N;
    localparam int NDUT   = 3;

    typedef struct {
        int          d;
        int          r;
        int          c;
        logic [31:0] exp;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start_v   [NDUT];
    logic                  ack_v     [NDUT];
    logic                  rom_en_v  [NDUT];
    logic [4:0]            rom_addr_v[NDUT];
    logic                  busy_v    [NDUT];
    logic                  valid_v   [NDUT];
    logic [NE*DATA_W-1:0]  mat_v     [NDUT];
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
    logic                  diag_v    [NDUT];
`endif
    logic [DATA_W-1:0]     rom_mem   [NDUT][32];
    logic [DATA_W-1:0]     pipe      [NDUT][3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // ROM model: returns junk when not enabled so mistimed captures are visible
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            pipe[d][0] <= rom_en_v[d] ? rom_mem[d][rom_addr_v[d]] : 32'hDEADBEEF;
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end

    matrix_loader #(.DATA_W(DATA_W), .N(N), .BASE_ADDR(0), .ROM_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .rom_en(rom_en_v[0]),
        .rom_addr(rom_addr_v[0]), .rom_data(pipe[0][0]), .busy(busy_v[0]),
        .mat_valid(valid_v[0]), .mat_ack(ack_v[0]), .matrix_flat(mat_v[0])
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        , .diag_zero(diag_v[0])
`endif
    );

    matrix_loader #(.DATA_W(DATA_W), .N(N), .BASE_ADDR(0), .ROM_LAT(3)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .rom_en(rom_en_v[1]),
        .rom_addr(rom_addr_v[1]), .rom_data(pipe[1][2]), .busy(busy_v[1]),
        .mat_valid(valid_v[1]), .mat_ack(ack_v[1]), .matrix_flat(mat_v[1])
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        , .diag_zero(diag_v[1])
`endif
    );

    matrix_loader #(.DATA_W(DATA_W), .N(N), .BASE_ADDR(20), .ROM_LAT(1)) dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .rom_en(rom_en_v[2]),
        .rom_addr(rom_addr_v[2]), .rom_data(pipe[2][0]), .busy(busy_v[2]),
        .mat_valid(valid_v[2]), .mat_ack(ack_v[2]), .matrix_flat(mat_v[2])
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        , .diag_zero(diag_v[2])
`endif
    );

    function automatic int base_of(input int d);
        return (d == 2) ? 20 : 0;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    function automatic logic [31:0] exp_elem(input int d, input int k);
        return rom_mem[d][(base_of(d) + k) % 32];
    endfunction

    function automatic logic [31:0] elem(input int d, input int k);
        return mat_v[d][DATA_W*k +: DATA_W];
    endfunction

    task automatic applyStimulus(input int d, input logic s, input logic a);
        start_v[d] = s;
        ack_v[d]   = a;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic fill_rom(input int d, input bit rnd, input bit nonzero);
        for (int a = 0; a < 32; a++) begin
            rom_mem[d][a] = rnd ? $urandom : 32'(100 + a);
            if (nonzero) rom_mem[d][a] = rom_mem[d][a] | 32'h1;
        end
    endtask

    task automatic check_idle_zero(input int d, input string tag);
        checkOutput($sformatf("%s d%0d rom_en", tag, d), 32'(rom_en_v[d]), 32'h0);
        checkOutput($sformatf("%s d%0d rom_addr", tag, d), 32'(rom_addr_v[d]), 32'h0);
        checkOutput($sformatf("%s d%0d busy", tag, d), 32'(busy_v[d]), 32'h0);
        checkOutput($sformatf("%s d%0d mat_valid", tag, d), 32'(valid_v[d]), 32'h0);
        checkOutput($sformatf("%s d%0d matrix_nonzero", tag, d), 32'(|mat_v[d]), 32'h0);
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        checkOutput($sformatf("%s d%0d diag_zero", tag, d), 32'(diag_v[d]), 32'h0);
`endif
    endtask

    // One full load on instance d, checked cycle by cycle; returns at the negedge of the first HOLD cycle
    task automatic run_load(input int d);
        int lat;
        int base;
        bit dz;
        lat  = lat_of(d);
        base = base_of(d);
        @(negedge clk);
        applyStimulus(d, 1'b1, 1'b0);
        @(posedge clk);
        for (int c = 1; c <= NE + lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) applyStimulus(d, 1'b0, 1'b0);
            checkOutput($sformatf("d%0d c%0d rom_en", d, c), 32'(rom_en_v[d]), 32'(c <= NE));
            checkOutput($sformatf("d%0d c%0d rom_addr", d, c), 32'(rom_addr_v[d]),
                        (c <= NE) ? 32'((base + c - 1) % 32) : 32'h0);
            checkOutput($sformatf("d%0d c%0d busy", d, c), 32'(busy_v[d]), 32'(c <= NE + lat));
            checkOutput($sformatf("d%0d c%0d mat_valid", d, c), 32'(valid_v[d]), 32'(c == NE + lat + 1));
        end
        for (int k = 0; k < NE; k++) begin
            checkOutput($sformatf("d%0d elem%0d", d, k), elem(d, k), exp_elem(d, k));
        end
        dz = 1'b0;
        for (int r = 0; r < N; r++) if (exp_elem(d, r*N + r) == 32'h0) dz = 1'b1;
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        checkOutput($sformatf("d%0d diag_zero", d), 32'(diag_v[d]), 32'(dz));
`endif
    endtask

    task automatic ack_load(input int d);
        applyStimulus(d, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(d, 1'b0, 1'b0);
        checkOutput($sformatf("d%0d after ack mat_valid", d), 32'(valid_v[d]), 32'h0);
        checkOutput($sformatf("d%0d after ack busy", d), 32'(busy_v[d]), 32'h0);
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        checkOutput($sformatf("d%0d after ack diag_zero", d), 32'(diag_v[d]), 32'h0);
`endif
    endtask

    initial begin
        vec_t                 tbl [11];
        logic [NE*DATA_W-1:0] snap;
        bit                   found;

        tbl[0]  = '{0, 1, 1, 32'd100};
        tbl[1]  = '{0, 3, 4, 32'd113};
        tbl[2]  = '{0, 5, 5, 32'd124};
        tbl[3]  = '{1, 1, 1, 32'd100};
        tbl[4]  = '{1, 3, 4, 32'd113};
        tbl[5]  = '{1, 5, 5, 32'd124};
        tbl[6]  = '{2, 1, 1, 32'd120};
        tbl[7]  = '{2, 2, 3, 32'd127};
        tbl[8]  = '{2, 3, 2, 32'd131};
        tbl[9]  = '{2, 3, 3, 32'd100};
        tbl[10] = '{2, 5, 5, 32'd112};

        for (int d = 0; d < NDUT; d++) begin
            applyStimulus(d, 1'b0, 1'b0);
            fill_rom(d, 1'b0, 1'b0);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_idle_zero(d, "reset");
        reset = 1'b1;

        // Deterministic loads; results read back afterwards from the retained IDLE contents
        for (int d = 0; d < NDUT; d++) begin
            run_load(d);
            ack_load(d);
        end
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("table%0d d%0d (%0d,%0d)", i, tbl[i].d, tbl[i].r, tbl[i].c),
                        mat_v[tbl[i].d][DATA_W*(N*(tbl[i].r-1) + (tbl[i].c-1)) +: DATA_W], tbl[i].exp);
        end

        // Handshake: stall in HOLD with stray start pulses, then simultaneous start+ack
        fill_rom(0, 1'b1, 1'b0);
        run_load(0);
        snap = mat_v[0];
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, (i % 3) == 0, 1'b0);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("stall%0d mat_valid", i), 32'(valid_v[0]), 32'h1);
            checkOutput($sformatf("stall%0d busy", i), 32'(busy_v[0]), 32'h0);
            checkOutput($sformatf("stall%0d matrix_stable", i), 32'(mat_v[0] == snap), 32'h1);
        end
        applyStimulus(0, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("start+ack mat_valid", 32'(valid_v[0]), 32'h0);
        checkOutput("start+ack busy", 32'(busy_v[0]), 32'h0);
        checkOutput("start+ack rom_en", 32'(rom_en_v[0]), 32'h0);
        checkOutput("idle retains matrix", 32'(mat_v[0] == snap), 32'h1);
        fill_rom(0, 1'b1, 1'b0);
        run_load(0);
        ack_load(0);

        // Reset while rom_addr is 10
        fill_rom(0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0);
        @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            applyStimulus(0, 1'b0, 1'b0);
            if (rom_en_v[0] && rom_addr_v[0] == 5'd10) found = 1'b1;
        end
        checkOutput("reach rom_addr 10", 32'(found), 32'h1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_zero(0, "midreset");
        reset = 1'b1;
        fill_rom(0, 1'b1, 1'b0);
        run_load(0);
        ack_load(0);

        // Random ROM contents on every variant
        for (int rep = 0; rep < 2; rep++) begin
            for (int d = 0; d < NDUT; d++) begin
                fill_rom(d, 1'b1, 1'b0);
                run_load(d);
                ack_load(d);
            end
        end

`ifdef MATRIX_LOADER_DIAG_CHECK_EN
        fill_rom(0, 1'b1, 1'b1);
        rom_mem[0][12] = 32'h0;
        run_load(0);
        checkOutput("diag (3,3)=0", 32'(diag_v[0]), 32'h1);
        ack_load(0);
        fill_rom(0, 1'b1, 1'b1);
        run_load(0);
        checkOutput("diag all nonzero", 32'(diag_v[0]), 32'h0);
        ack_load(0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for the 5x5 matrix inverse stage. It walks the coefficient ROM from a base address, captures 25 row-major 32-bit words, and presents them as one flat matrix bus with a valid/ack handshake. This replaces the bench-driven address sweep with a self-sequenced load, so the inverse stage sees a complete, stable matrix before it starts.

## Interface
Parameters:
- DATA_W, 32, element width in bits
- N, 5, matrix dimension; N*N must be ≤ 32
- BASE_ADDR, 0, ROM address of element (1,1)
- ROM_LAT, 1, ROM read latency in cycles (1..3)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- start  in  1  load request, sampled in IDLE only
- rom_en  out  1  ROM read enable
- rom_addr  out  5  ROM address
- rom_data  in  DATA_W  ROM read data, ROM_LAT cycles after rom_addr/rom_en
- busy  out  1  high from the start acceptance until mat_valid rises
- mat_valid  out  1  matrix_flat complete and stable
- mat_ack  in  1  downstream consumed matrix
- matrix_flat  out  N*N*DATA_W  element (r,c), 1-based, at bits [DATA_W*(N*(r-1)+(c-1)) +: DATA_W]
- diag_zero  out  1  any diagonal element is zero (present only with the macro)

## Operation
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- IDLE: start=1 → FETCH; rd_cnt←0; wr_cnt←0.
- FETCH: rom_en=1, rom_addr=BASE_ADDR+rd_cnt (mod 32); rd_cnt increments each cycle; after rd_cnt=N*N-1 issued → DRAIN.
- Capture: rom_en delayed by a ROM_LAT-deep shift register gives cap_en; on cap_en, element wr_cnt←rom_data, wr_cnt++.
- DRAIN: rom_en=0; wait until wr_cnt=N*N → HOLD.
- HOLD: mat_valid=1; matrix_flat frozen; mat_ack=1 → IDLE, mat_valid←0 on the next edge.
- start outside IDLE ignored (no queuing). mat_ack outside HOLD ignored.
- start and mat_ack both high in HOLD: ack honoured, start ignored; new load needs start in IDLE.
- matrix_flat retains its last contents in IDLE and is overwritten element-by-element during the next load.

## Timing
- Reset (reset=0 at an edge): state IDLE, rom_en=0, rom_addr=0, busy=0, mat_valid=0, matrix_flat=0, diag_zero=0, counters and cap shift register cleared. Applies mid-load: in-flight ROM returns are discarded.
- Start sampled at edge E0 → rom_addr=BASE_ADDR, rom_en=1 in cycle 1; addresses occupy cycles 1..N*N at one per cycle, with no gaps.
- Data for the address in cycle c is captured at the end of cycle c+ROM_LAT.
- mat_valid rises in cycle N*N+ROM_LAT+1 (27 for defaults); busy falls in the same cycle.
- Throughput: a new load starts no earlier than one cycle after the ack edge.

## Configuration
- MATRIX_LOADER_DIAG_CHECK_EN defined: adds the diag_zero port. It is registered, computed on HOLD entry as OR over r of (element(r,r)==0), and cleared on leaving HOLD or on reset. Consumers use it to skip inversion of a trivially singular pivot.
- Undefined: no diag_zero port and no comparison logic; all other behaviour is identical.

## Test plan
- Basic load: ROM[a]=100+a, BASE_ADDR=0, ROM_LAT=1; pulse start → mat_valid in cycle 27; element(1,1)=100, (3,4)=113, (5,5)=124; busy high in cycles 1..26.
- Latency sweep: ROM_LAT=3, same ROM → mat_valid in cycle 29; contents identical to the basic load.
- Base wrap: BASE_ADDR=20 → rom_addr sequence 20..31, then 0..12; element(1,1)=ROM[20], element(5,5)=ROM[12].
- Handshake: hold mat_ack=0 for 10 cycles in HOLD → matrix_flat stable and start pulses ignored; mat_ack=1 → mat_valid=0 next cycle; start → second load completes.
- Reset mid-load: drive reset=0 at rom_addr=10 → next cycle all outputs are zero; after release, start → a full clean load with correct values.
- Diag check (macro on): ROM[12]=0 (element (3,3)) → diag_zero=1 with mat_valid; all-nonzero ROM → diag_zero=0.
